// File: rtl/seq_vedic_div_if.sv
// rtl/seq_vedic_div_if.sv - start/busy/done handshake and operand/result bus of seq_vedic_div
interface seq_vedic_div_if #(
    parameter int WIDTH = 24,
    parameter int RSWID = 48
);
    logic             start;
    logic [RSWID-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             busy;
    logic             done;
    logic [RSWID-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dvz;

    modport master (
        output start, dvd, dvs,
        input  busy, done, quo, rem, dvz
    );

    modport slave (
        input  start, dvd, dvs,
        output busy, done, quo, rem, dvz
    );
endinterface

// File: rtl/seq_vedic_div.sv
// rtl/seq_vedic_div.sv - iterative restoring unsigned divider (optional SEQ_VEDIC_DIV_RADIX4_EN)
module seq_vedic_div #(
    parameter int WIDTH = 24,
    parameter int RSWID = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_vedic_div_if.slave bus
);

    localparam int CW = $clog2(RSWID);

`ifdef SEQ_VEDIC_DIV_RADIX4_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(RSWID/2 - 1);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(RSWID - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             busy_c;
    logic             done_c;

    logic [CW-1:0]    cnt;
    logic [RSWID-1:0] dvd_sh;
    logic [WIDTH-1:0] dvs_r;
    // Stored partial remainder is always < divisor, so WIDTH bits suffice;
    // the shifted value fed to the comparator is WIDTH+1 bits.
    logic [WIDTH-1:0] pr;
    logic [RSWID-1:0] q_sh;

    logic [RSWID-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic             dvz_r;

    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   t1;
    logic             ge1;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] pr_nx;
    logic [RSWID-1:0] q_nx;
    logic [RSWID-1:0] dvd_nx;
    logic             last;
`ifdef SEQ_VEDIC_DIV_RADIX4_EN
    logic [WIDTH:0]   t2;
    logic             ge2;
    logic [WIDTH-1:0] p2;
`endif

    // Compare/subtract stage(s): shift in the next dividend bit(s) and restore.
    always_comb begin
        dvs_ext = {1'b0, dvs_r};
        t1      = {pr, dvd_sh[RSWID-1]};
        ge1     = (t1 >= dvs_ext);
        p1      = ge1 ? WIDTH'(t1 - dvs_ext) : t1[WIDTH-1:0];
`ifdef SEQ_VEDIC_DIV_RADIX4_EN
        t2      = {p1, dvd_sh[RSWID-2]};
        ge2     = (t2 >= dvs_ext);
        p2      = ge2 ? WIDTH'(t2 - dvs_ext) : t2[WIDTH-1:0];
        pr_nx   = p2;
        q_nx    = {q_sh[RSWID-3:0], ge1, ge2};
        dvd_nx  = {dvd_sh[RSWID-3:0], 2'b00};
`else
        pr_nx   = p1;
        q_nx    = {q_sh[RSWID-2:0], ge1};
        dvd_nx  = {dvd_sh[RSWID-2:0], 1'b0};
`endif
        last    = (cnt == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; a zero divisor skips straight to DONE.
    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.dvs != '0) ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                busy_c = 1'b1;
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done_c   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result load on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dvd_sh <= '0;
            dvs_r  <= '0;
            pr     <= '0;
            q_sh   <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            dvz_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.dvs != '0) begin
                            dvd_sh <= bus.dvd;
                            dvs_r  <= bus.dvs;
                            pr     <= '0;
                            q_sh   <= '0;
                            cnt    <= '0;
                        end else begin
                            dvz_r  <= 1'b1;
                            quo_r  <= '1;
                            rem_r  <= bus.dvd[WIDTH-1:0];
                        end
                    end
                end
                S_CALC: begin
                    dvd_sh <= dvd_nx;
                    pr     <= pr_nx;
                    q_sh   <= q_nx;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        quo_r <= q_nx;
                        rem_r <= pr_nx;
                        dvz_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.quo  = quo_r;
    assign bus.rem  = rem_r;
    assign bus.dvz  = dvz_r;

endmodule

// File: tb/tb_seq_vedic_div.sv
// tb/tb_seq_vedic_div.sv - scoreboard testbench for seq_vedic_div
module tb_seq_vedic_div;

    localparam int WIDTH = 24;
    localparam int RSWID = 48;
`ifdef SEQ_VEDIC_DIV_RADIX4_EN
    localparam int NITER = RSWID/2;
`else
    localparam int NITER = RSWID;
`endif

    typedef struct {
        logic [RSWID-1:0] quo;
        logic [WIDTH-1:0] rem;
        logic             dvz;
        int               cyc;
        int               nbusy;
        string            name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   errors = 0;
    int   bcnt = 0;
    int   s;

    exp_t exp_q[$];
    logic [RSWID-1:0] held_quo = '0;
    logic [WIDTH-1:0] held_rem = '0;
    logic             held_dvz = 1'b0;

    seq_vedic_div_if #(.WIDTH(WIDTH), .RSWID(RSWID)) bus ();

    seq_vedic_div #(.WIDTH(WIDTH), .RSWID(RSWID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks held results otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt = 0;
        end else begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_quo"},   64'(bus.quo), 64'(e.quo));
                    chk({e.name, "_rem"},   64'(bus.rem), 64'(e.rem));
                    chk({e.name, "_dvz"},   64'(bus.dvz), 64'(e.dvz));
                    chk({e.name, "_cycle"}, 64'(cyc),     64'(e.cyc));
                    chk({e.name, "_busy"},  64'(bcnt),    64'(e.nbusy));
                    held_quo = e.quo;
                    held_rem = e.rem;
                    held_dvz = e.dvz;
                end
                bcnt = 0;
            end else begin
                if ((bus.quo !== held_quo) || (bus.rem !== held_rem) || (bus.dvz !== held_dvz)) begin
                    chk("held_quo", 64'(bus.quo), 64'(held_quo));
                    chk("held_rem", 64'(bus.rem), 64'(held_rem));
                    chk("held_dvz", 64'(bus.dvz), 64'(held_dvz));
                end
            end
        end
    end

    task automatic issue(input logic [RSWID-1:0] dvd, input logic [WIDTH-1:0] dvs,
                         input logic [RSWID-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic ez, input string name, output int st);
        exp_t e;
        @(negedge clk);
        #1;
        bus.dvd   = dvd;
        bus.dvs   = dvs;
        bus.start = 1'b1;
        st        = cyc;
        e.quo     = eq;
        e.rem     = er;
        e.dvz     = ez;
        e.cyc     = cyc + (ez ? 1 : NITER + 1);
        e.nbusy   = ez ? 0 : NITER;
        e.name    = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dvd   = '0;
        bus.dvs   = '0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.dvd   = '0;
        bus.dvs   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_quo",  64'(bus.quo),  64'd0);
        chk("reset_rem",  64'(bus.rem),  64'd0);
        chk("reset_dvz",  64'(bus.dvz),  64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        issue(48'd1000, 24'd7, 48'd142, 24'd6, 1'b0, "t1_1000_7", s);
        wait_done("t1");
        issue(48'hFFFFFE000001, 24'hFFFFFF, 48'h000000FFFFFF, 24'd0, 1'b0, "t2_square", s);
        wait_done("t2");
        issue(48'hFFFFFFFFFFFF, 24'd1, 48'hFFFFFFFFFFFF, 24'd0, 1'b0, "t3_div1", s);
        wait_done("t3a");
        issue(48'd5, 24'hFFFFFF, 48'd0, 24'd5, 1'b0, "t3_small", s);
        wait_done("t3b");
        issue(48'h123456, 24'd0, 48'hFFFFFFFFFFFF, 24'h123456, 1'b1, "t4_dvz", s);
        wait_done("t4");
        issue(48'h800000000000, 24'h800000, 48'h000001000000, 24'd0, 1'b0, "t_pow2", s);
        wait_done("t_pow2");

        issue(48'd100, 24'd3, 48'd33, 24'd1, 1'b0, "t5_ignore", s);
        while (cyc < s + 10) @(negedge clk);
        #1;
        bus.dvd   = 48'd9;
        bus.dvs   = 24'd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dvd   = '0;
        bus.dvs   = '0;
        wait_done("t5");

        issue(48'd12345678, 24'd1000, 48'd12345, 24'd678, 1'b0, "t6_abort", s);
        while (cyc < s + 20) @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        held_quo = '0;
        held_rem = '0;
        held_dvz = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_quo",  64'(bus.quo),  64'd0);
        chk("abort_rem",  64'(bus.rem),  64'd0);
        chk("abort_dvz",  64'(bus.dvz),  64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        issue(48'd12345678, 24'd1000, 48'd12345, 24'd678, 1'b0, "t6_after", s);
        wait_done("t6");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
